// File: rtl/stream_pool.sv
`default_nettype none
// ============================================================================
// Module      : stream_pool
// Description : Streaming 2-D pooling engine. Accepts one multi-channel pixel
//               per beat in raster order and produces one pooled pixel per
//               non-overlapping KSIZE x KSIZE window. The pooling mode is
//               max (0) or average (1) and is chosen per frame.
//               Only one row of partial window results is held on-chip.
// Ports       : clk, rst_n          clock, asynchronous active-low reset
//               mode                pooling mode, latched on the frame's first beat
//               in_valid/in_ready   input handshake
//               in_data             DATACHANNEL samples of BITWIDTH bits
//               out_valid/out_ready output handshake
//               out_data            pooled pixel, same packing as in_data
//               frame_done          one-cycle pulse after the last output of a
//                                   frame is accepted
// Revision    : 1.0 - initial release
// ============================================================================
module stream_pool #(
    parameter int BITWIDTH    = 16,
    parameter int DATAWIDTH   = 28,
    parameter int DATAHEIGHT  = 28,
    parameter int DATACHANNEL = 4,
    parameter int KSIZE       = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            mode,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [BITWIDTH*DATACHANNEL-1:0] in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [BITWIDTH*DATACHANNEL-1:0] out_data,
    output logic                            frame_done
);

    localparam int c_KB   = $clog2(KSIZE);
    localparam int c_SH   = 2 * c_KB;
    localparam int ACCW   = BITWIDTH + c_SH;
    localparam int c_OW   = DATAWIDTH / KSIZE;
    localparam int c_OH   = DATAHEIGHT / KSIZE;
    localparam int c_CW   = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
    localparam int c_RW   = (DATAHEIGHT > 1) ? $clog2(DATAHEIGHT) : 1;
    localparam int c_IW   = (c_OW > 1) ? $clog2(c_OW) : 1;
    localparam int c_DW   = BITWIDTH * DATACHANNEL;

    localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(DATAWIDTH - 1);
    localparam logic [c_RW-1:0] c_ROW_LAST = c_RW'(DATAHEIGHT - 1);
    // Last column/row that still belongs to a complete window
    localparam logic [c_CW-1:0] c_COL_LIM  = c_CW'(c_OW * KSIZE - 1);
    localparam logic [c_RW-1:0] c_ROW_LIM  = c_RW'(c_OH * KSIZE - 1);

    logic [c_CW-1:0] r_col;
    logic [c_RW-1:0] r_row;
    logic            r_mode;
    logic            r_out_valid;
    logic [c_DW-1:0] r_out_data;
    logic            r_out_last;
    logic            r_frame_done;

    logic            w_acc;
    logic            w_origin;
    logic            w_mode;
    logic            w_inside;
    logic            w_first;
    logic            w_last;
    logic            w_frame_last;
    logic [c_IW-1:0] w_idx;
    logic [c_DW-1:0] w_res;

    assign in_ready   = !r_out_valid || out_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign frame_done = r_frame_done;

    assign w_acc    = in_valid && in_ready;
    assign w_origin = (r_col == '0) && (r_row == '0);
    // The first beat of a frame uses the live mode input so that beat is
    // pooled with the same mode that gets latched for the rest of the frame.
    assign w_mode   = w_origin ? mode : r_mode;
    assign w_inside = (r_col <= c_COL_LIM) && (r_row <= c_ROW_LIM);
    // KSIZE is a power of two, so the in-window offset is the low index bits
    assign w_first  = (r_col[c_KB-1:0] == '0) && (r_row[c_KB-1:0] == '0);
    assign w_last   = (&r_col[c_KB-1:0]) && (&r_row[c_KB-1:0]);
    assign w_frame_last = (r_col == c_COL_LIM) && (r_row == c_ROW_LIM);
    assign w_idx    = c_IW'(r_col >> c_KB);

    // ------------------------------------------------------------------------
    // Per-channel partial accumulation
    // ------------------------------------------------------------------------
    for (genvar c = 0; c < DATACHANNEL; c++) begin : g_ch
        logic signed [ACCW-1:0]     r_buf [c_OW];
        logic signed [BITWIDTH-1:0] w_smp;
        logic signed [ACCW-1:0]     w_ext;
        logic signed [ACCW-1:0]     w_ent;
        logic signed [ACCW-1:0]     w_comb;
        logic signed [ACCW-1:0]     w_avg;

        assign w_smp = in_data[c*BITWIDTH +: BITWIDTH];
        assign w_ext = {{c_SH{w_smp[BITWIDTH-1]}}, w_smp};
        assign w_ent = r_buf[w_idx];

        always_comb begin
            w_comb = w_ext;
            if (!w_first) begin
                if (w_mode) begin
                    w_comb = w_ent + w_ext;
                end else if (w_ent > w_ext) begin
                    w_comb = w_ent;
                end
            end
        end

        // Arithmetic shift gives floor division of the window sum
        assign w_avg = w_comb >>> c_SH;
        assign w_res[c*BITWIDTH +: BITWIDTH] = w_mode ? w_avg[BITWIDTH-1:0]
                                                      : w_comb[BITWIDTH-1:0];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < c_OW; i++) begin
                    r_buf[i] <= '0;
                end
            end else if (w_acc && w_inside && !w_last) begin
                r_buf[w_idx] <= w_comb;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Raster position and frame mode
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col  <= '0;
            r_row  <= '0;
            r_mode <= 1'b0;
        end else if (w_acc) begin
            if (w_origin) begin
                r_mode <= mode;
            end
            if (r_col == c_COL_LAST) begin
                r_col <= '0;
                r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Single output register; a completing window may reload it in the same
    // cycle the previous result is popped.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= r_out_valid && out_ready && r_out_last;
            if (w_acc && w_inside && w_last) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_res;
                r_out_last  <= w_frame_last;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_pool.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_pool
// Description : Scoreboard testbench for stream_pool. Whole frames are built
//               in an array, the expected pooled outputs are computed from the
//               window definition and queued, and a negedge monitor pops and
//               compares every accepted output beat.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_pool;

    localparam int BW = 16;
    localparam int W  = 5;
    localparam int H  = 5;
    localparam int CH = 2;
    localparam int K  = 2;
    localparam int OW = W / K;
    localparam int OH = H / K;
    localparam int DW = BW * CH;

    logic          clk;
    logic          rst_n;
    logic          mode;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          frame_done;

    stream_pool #(
        .BITWIDTH   (BW),
        .DATAWIDTH  (W),
        .DATAHEIGHT (H),
        .DATACHANNEL(CH),
        .KSIZE      (K)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        bit            last;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            pix [H][W][CH];
    bit            hold = 0;
    bit            rand_ready = 0;
    bit            gaps = 0;
    bit            exp_fd = 0;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data = '0;
    int            fd_pulses = 0;
    int            frames_done_exp = 0;

    function automatic int floor_div(input int a, input int b);
        int r;
        r = a % b;
        if (r < 0) r = r + b;
        return (a - r) / b;
    endfunction

    function automatic int rnd_s16();
        case ($urandom % 8)
            0:       return 32767;
            1:       return -32768;
            2:       return int'($urandom % 5) - 2;
            default: return int'($urandom % 65536) - 32768;
        endcase
    endfunction

    // Expected outputs straight from the window definition
    task automatic push_expected(input bit m);
        for (int oy = 0; oy < OH; oy++) begin
            for (int ox = 0; ox < OW; ox++) begin
                exp_t e;
                e.data = '0;
                for (int c = 0; c < CH; c++) begin
                    int mx;
                    int sum;
                    int v;
                    mx  = -100000;
                    sum = 0;
                    for (int dy = 0; dy < K; dy++) begin
                        for (int dx = 0; dx < K; dx++) begin
                            int s;
                            s = pix[oy*K+dy][ox*K+dx][c];
                            sum = sum + s;
                            if (s > mx) mx = s;
                        end
                    end
                    v = m ? floor_div(sum, K*K) : mx;
                    e.data[c*BW +: BW] = v[BW-1:0];
                end
                e.last = (oy == OH-1) && (ox == OW-1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic send_frame(input bit m, input bit toggle, input int nbeats);
        int beat;
        push_expected(m);
        beat = 0;
        for (int r = 0; r < H; r++) begin
            for (int col = 0; col < W; col++) begin
                if (beat < nbeats) begin
                    int t;
                    if (gaps && ($urandom % 4 == 0)) begin
                        in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    in_valid = 1'b1;
                    for (int c = 0; c < CH; c++) begin
                        int s;
                        s = pix[r][col][c];
                        in_data[c*BW +: BW] = s[BW-1:0];
                    end
                    mode = (beat == 0 || !toggle) ? m : 1'($urandom % 2);
                    t = 0;
                    @(negedge clk);
                    while (!in_ready && t < 1000) begin
                        @(negedge clk);
                        t++;
                    end
                    if (t >= 1000) begin
                        checks++;
                        errors++;
                        $display("FAIL in_ready_timeout: in_ready=%0b required=1 at beat %0d", in_ready, beat);
                    end
                    @(posedge clk);
                    #1;
                    beat++;
                end
            end
        end
        in_valid = 1'b0;
        if (nbeats >= W*H) frames_done_exp++;
    endtask

    task automatic fill_random();
        for (int r = 0; r < H; r++)
            for (int col = 0; col < W; col++)
                for (int c = 0; c < CH; c++)
                    pix[r][col][c] = rnd_s16();
    endtask

    // Downstream ready generator
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = hold ? 1'b0 : (rand_ready ? ($urandom % 3 != 0) : 1'b1);
        end
    end

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                checks++;
                if (frame_done !== exp_fd) begin
                    errors++;
                    $display("FAIL frame_done: got %0b required %0b", frame_done, exp_fd);
                end
                if (frame_done === 1'b1) fd_pulses++;
                checks++;
                if (in_ready !== (!out_valid || out_ready)) begin
                    errors++;
                    $display("FAIL in_ready_rule: got %0b required %0b", in_ready, !out_valid || out_ready);
                end
                if (prev_stall) begin
                    checks++;
                    if (out_valid !== 1'b1 || out_data !== prev_data) begin
                        errors++;
                        $display("FAIL stall_hold: valid=%0b data=%h required valid=1 data=%h", out_valid, out_data, prev_data);
                    end
                end
                exp_fd = 1'b0;
                if (out_valid && out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output: got %h required no output", out_data);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        if (out_data !== e.data) begin
                            errors++;
                            $display("FAIL out_data: got %h required %h", out_data, e.data);
                        end
                        exp_fd = e.last;
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
            end else begin
                exp_fd     = 1'b0;
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        int t;
        rst_n    = 1'b0;
        mode     = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: in_ready=%0b out_valid=%0b out_data=%h frame_done=%0b required 1 0 0 0",
                     in_ready, out_valid, out_data, frame_done);
        end
        @(posedge clk);
        #1;

        // Max pooling on a raster ramp with a 5-cycle downstream stall
        for (int r = 0; r < H; r++)
            for (int col = 0; col < W; col++) begin
                pix[r][col][0] = r*W + col;
                pix[r][col][1] = -(r*W + col) * 100;
            end
        hold = 1'b1;
        fork
            send_frame(1'b0, 1'b0, W*H);
            begin
                int tt;
                tt = 0;
                @(negedge clk);
                while (!out_valid && tt < 200) begin
                    @(negedge clk);
                    tt++;
                end
                if (tt >= 200) begin
                    checks++;
                    errors++;
                    $display("FAIL stall_wait: out_valid=%0b required 1", out_valid);
                end
                repeat (5) begin
                    checks++;
                    if (in_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_in_ready: got %0b required 0", in_ready);
                    end
                    @(negedge clk);
                end
                hold = 1'b0;
            end
        join

        // Average pooling corner windows
        fill_random();
        for (int dy = 0; dy < K; dy++)
            for (int dx = 0; dx < K; dx++) begin
                pix[dy][dx][0]     = -(dy*K + dx + 1);
                pix[dy][2+dx][0]   = (dy == 1 && dx == 1) ? 2 : 1;
                pix[2+dy][dx][0]   = 32767;
                pix[2+dy][2+dx][0] = -32768;
            end
        send_frame(1'b1, 1'b0, W*H);

        // Mode toggled mid-frame, then an average frame
        fill_random();
        send_frame(1'b0, 1'b1, W*H);
        fill_random();
        send_frame(1'b1, 1'b0, W*H);

        // Random frames with input gaps and random backpressure
        gaps       = 1'b1;
        rand_ready = 1'b1;
        for (int f = 0; f < 12; f++) begin
            fill_random();
            send_frame(1'($urandom % 2), 1'($urandom % 2), W*H);
        end
        gaps       = 1'b0;
        rand_ready = 1'b0;

        // Drain before the reset test
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;

        // Asynchronous reset just after a window completes
        fill_random();
        send_frame(1'($urandom % 2), 1'b0, 9);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_valid: got %0b required 1", out_valid);
        end
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        exp_fd     = 1'b0;
        prev_stall = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: out_valid=%0b required 0", out_valid);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        fill_random();
        send_frame(1'b1, 1'b0, W*H);

        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        repeat (4) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL output_count: %0d outputs still missing, required 0", exp_q.size());
        end
        checks++;
        if (fd_pulses != frames_done_exp) begin
            errors++;
            $display("FAIL frame_done_count: got %0d required %0d", fd_pulses, frames_done_exp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
